// File: rtl/tl_slave_buffer_if.sv
// TileLink channel payload types and the A-E bus bundle seen by tl_slave_buffer.
// The Master modport is the buffer's view: it consumes A/C/E and produces B/D.
package tl_pkg;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [7:0]  source;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
    } A_chan_bits_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [7:0]  source;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
    } B_chan_bits_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [7:0]  source;
        logic [31:0] address;
        logic [31:0] data;
        logic        corrupt;
    } C_chan_bits_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [3:0]  size;
        logic [7:0]  source;
        logic [7:0]  sink;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } D_chan_bits_t;

    typedef struct packed {
        logic [7:0] sink;
    } E_chan_bits_t;

endpackage

interface TL_BUS;
    import tl_pkg::*;

    logic         a_valid;
    logic         a_ready;
    A_chan_bits_t a_bits;
    logic         b_valid;
    logic         b_ready;
    B_chan_bits_t b_bits;
    logic         c_valid;
    logic         c_ready;
    C_chan_bits_t c_bits;
    logic         d_valid;
    logic         d_ready;
    D_chan_bits_t d_bits;
    logic         e_valid;
    logic         e_ready;
    E_chan_bits_t e_bits;

    modport Master (
        input  a_valid, a_bits, output a_ready,
        output b_valid, b_bits, input  b_ready,
        input  c_valid, c_bits, output c_ready,
        output d_valid, d_bits, input  d_ready,
        input  e_valid, e_bits, output e_ready
    );

    modport Slave (
        output a_valid, a_bits, input  a_ready,
        input  b_valid, b_bits, output b_ready,
        output c_valid, c_bits, input  c_ready,
        input  d_valid, d_bits, output d_ready,
        output e_valid, e_bits, input  e_ready
    );

endinterface

// File: rtl/tl_slave_buffer.sv
// Per-channel FIFO decoupling between a TileLink bus bundle and a slave device,
// with occupancy and idle reporting. A depth of 0 makes a channel a plain wire.
module tl_slave_buffer_chan #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_valid,
    output logic       p_ready,
    input  T           p_bits,
    output logic       q_valid,
    input  logic       q_ready,
    output T           q_bits,
    output logic [7:0] cnt_o
);

    if (DEPTH == 0) begin : g_pass
        assign q_valid = p_valid;
        assign q_bits  = p_bits;
        assign p_ready = q_ready;
        assign cnt_o   = '0;
    end else begin : g_fifo
        localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam int CW = $clog2(DEPTH + 1);
        // Storage is rounded up to a power of two so pointer indexing is always in range.
        localparam int MW = 1 << PW;

        logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
        logic [CW-1:0] cnt_q, cnt_d;
        T              mem_q [MW];
        T              mem_d [MW];
        logic          push, pop;

        always_comb begin
            p_ready = (cnt_q != CW'(DEPTH));
            q_valid = (cnt_q != '0);
            q_bits  = mem_q[rp_q];
            push    = p_valid & p_ready;
            pop     = q_valid & q_ready;
            wp_d    = wp_q;
            rp_d    = rp_q;
            cnt_d   = cnt_q;
            mem_d   = mem_q;
            if (push) begin
                mem_d[wp_q] = p_bits;
                wp_d        = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
            end
            if (pop) begin
                rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                wp_q  <= wp_d;
                rp_q  <= rp_d;
                cnt_q <= cnt_d;
            end
        end

        always_ff @(posedge clk) begin
            mem_q <= mem_d;
        end

        assign cnt_o = 8'(cnt_q);
    end

endmodule

module tl_slave_buffer #(
    parameter int A_DEPTH = 2,
    parameter int B_DEPTH = 2,
    parameter int C_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int E_DEPTH = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    TL_BUS.Master                slave,
    output logic                 A_valid_o,
    input  logic                 A_ready_i,
    output tl_pkg::A_chan_bits_t A_bits_o,
    input  logic                 B_valid_i,
    output logic                 B_ready_o,
    input  tl_pkg::B_chan_bits_t B_bits_i,
    output logic                 C_valid_o,
    input  logic                 C_ready_i,
    output tl_pkg::C_chan_bits_t C_bits_o,
    input  logic                 D_valid_i,
    output logic                 D_ready_o,
    input  tl_pkg::D_chan_bits_t D_bits_i,
    output logic                 E_valid_o,
    input  logic                 E_ready_i,
    output tl_pkg::E_chan_bits_t E_bits_o,
    output logic [4:0][7:0]      occ_o,
    output logic                 idle_o
);

    if (A_DEPTH < 0 || B_DEPTH < 0 || C_DEPTH < 0 || D_DEPTH < 0 || E_DEPTH < 0) begin : g_neg_depth
        $fatal(1, "tl_slave_buffer: channel depth must not be negative");
    end
    if (A_DEPTH > 255 || B_DEPTH > 255 || C_DEPTH > 255 || D_DEPTH > 255 || E_DEPTH > 255) begin : g_big_depth
        $fatal(1, "tl_slave_buffer: channel depth must not exceed 255");
    end

    tl_slave_buffer_chan #(.DEPTH(A_DEPTH), .T(tl_pkg::A_chan_bits_t)) u_a (
        .clk(clk_i), .rst(rst_i),
        .p_valid(slave.a_valid), .p_ready(slave.a_ready), .p_bits(slave.a_bits),
        .q_valid(A_valid_o), .q_ready(A_ready_i), .q_bits(A_bits_o),
        .cnt_o(occ_o[0])
    );

    tl_slave_buffer_chan #(.DEPTH(B_DEPTH), .T(tl_pkg::B_chan_bits_t)) u_b (
        .clk(clk_i), .rst(rst_i),
        .p_valid(B_valid_i), .p_ready(B_ready_o), .p_bits(B_bits_i),
        .q_valid(slave.b_valid), .q_ready(slave.b_ready), .q_bits(slave.b_bits),
        .cnt_o(occ_o[1])
    );

    tl_slave_buffer_chan #(.DEPTH(C_DEPTH), .T(tl_pkg::C_chan_bits_t)) u_c (
        .clk(clk_i), .rst(rst_i),
        .p_valid(slave.c_valid), .p_ready(slave.c_ready), .p_bits(slave.c_bits),
        .q_valid(C_valid_o), .q_ready(C_ready_i), .q_bits(C_bits_o),
        .cnt_o(occ_o[2])
    );

    tl_slave_buffer_chan #(.DEPTH(D_DEPTH), .T(tl_pkg::D_chan_bits_t)) u_d (
        .clk(clk_i), .rst(rst_i),
        .p_valid(D_valid_i), .p_ready(D_ready_o), .p_bits(D_bits_i),
        .q_valid(slave.d_valid), .q_ready(slave.d_ready), .q_bits(slave.d_bits),
        .cnt_o(occ_o[3])
    );

    tl_slave_buffer_chan #(.DEPTH(E_DEPTH), .T(tl_pkg::E_chan_bits_t)) u_e (
        .clk(clk_i), .rst(rst_i),
        .p_valid(slave.e_valid), .p_ready(slave.e_ready), .p_bits(slave.e_bits),
        .q_valid(E_valid_o), .q_ready(E_ready_i), .q_bits(E_bits_o),
        .cnt_o(occ_o[4])
    );

    // Pass-through channels report zero, so this only looks at buffered counts.
    assign idle_o = (occ_o == '0);

endmodule
